// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: seek to lo, N sweeps lo->hi->lo.
// Optional endpoint dwell states are enabled by defining SWEEP_DWELL_EN.
module counter_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CW-1:0]    n_sweeps,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    sweep_cnt
);

  if (DWELL < 1) begin : g_bad_dwell
    $error("DWELL must be at least 1");
  end

`ifdef SWEEP_DWELL_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_UP, S_DOWN, S_DONE, S_DWELL_HI, S_DWELL_LO
  } state_t;

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [DW-1:0] dwell_q;
  logic          dwell_last;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_UP, S_DOWN, S_DONE
  } state_t;
`endif

  state_t          state, state_d;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [CW-1:0]    n_q;
  logic             accept, reject, sweep_inc, last_sweep;

  assign last_sweep = ((sweep_cnt + CW'(1)) == n_q);

`ifdef SWEEP_DWELL_EN
  assign dwell_last = (dwell_q == DW'(DWELL - 1));
`endif

  always_comb begin
    state_d   = state;
    cnt_en    = 1'b0;
    cnt_up    = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    sweep_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if ((lo < hi) && (n_sweeps != '0)) begin
            accept  = 1'b1;
            state_d = S_SEEK;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_SEEK: begin
        cnt_en = (count_in != lo_q);
        cnt_up = (count_in < lo_q);
        if (count_in == lo_q) state_d = S_UP;
      end
      S_UP: begin
        cnt_en = 1'b1;
        if (count_in != hi_q) begin
          cnt_up = 1'b1;
        end else begin
`ifdef SWEEP_DWELL_EN
          cnt_en  = 1'b0;
          state_d = S_DWELL_HI;
`else
          state_d = S_DOWN;
`endif
        end
      end
      S_DOWN: begin
        if (count_in != lo_q) begin
          cnt_en = 1'b1;
        end else begin
          sweep_inc = 1'b1;
          if (last_sweep) begin
            state_d = S_DONE;
          end else begin
`ifdef SWEEP_DWELL_EN
            state_d = S_DWELL_LO;
`else
            cnt_en  = 1'b1;
            cnt_up  = 1'b1;
            state_d = S_UP;
`endif
          end
        end
      end
`ifdef SWEEP_DWELL_EN
      // The last dwell cycle already steps away so each endpoint shows for 1+DWELL cycles.
      S_DWELL_HI: begin
        if (dwell_last) begin
          cnt_en  = 1'b1;
          state_d = S_DOWN;
        end
      end
      S_DWELL_LO: begin
        if (dwell_last) begin
          cnt_en  = 1'b1;
          cnt_up  = 1'b1;
          state_d = S_UP;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything decided above, including a same-cycle start.
    if (abort) begin
      state_d   = S_IDLE;
      cnt_en    = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      sweep_inc = 1'b0;
    end
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= '0;
      sweep_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_d;
      err   <= reject;
      if (accept) begin
        lo_q      <= lo;
        hi_q      <= hi;
        n_q       <= n_sweeps;
        sweep_cnt <= '0;
      end else if (sweep_inc) begin
        sweep_cnt <= sweep_cnt + CW'(1);
      end
    end
  end

`ifdef SWEEP_DWELL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (((state == S_DWELL_HI) || (state == S_DWELL_LO)) && (state_d == state)) begin
      dwell_q <= dwell_q + DW'(1);
    end else begin
      dwell_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural up/down counter in the loop.
// Defining SWEEP_DWELL_EN selects the dwell scenario instead of the plain sweep scenarios.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lo = '0;
  logic [7:0] hi = '0;
  logic [7:0] n_sweeps = '0;
  logic [7:0] count;
  logic       cnt_en, cnt_up, busy, done, err;
  logic [7:0] sweep_cnt;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.WIDTH(8), .CW(8), .DWELL(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .count_in(count),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy), .done(done),
    .err(err), .sweep_cnt(sweep_cnt)
  );

  // External registered counter driven by the sequencer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (load)   count <= load_val;
    else if (cnt_en) count <= cnt_up ? count + 8'd1 : count - 8'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int l, input int h, input int n);
    lo = 8'(l); hi = 8'(h); n_sweeps = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({cnt_en, cnt_up, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {cnt_en, cnt_up, busy, done, err});
    end
    checks++;
    if (sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_sweep_cnt: got %0d expected 0", sweep_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int exp_c[18] = '{0,1,2,2,3,4,5,4,3,2,3,4,5,4,3,2,2,2};
    start_run(2, 5, 2);
    for (int k = 1; k <= 18; k++) begin
      checks++;
      if (count !== 8'(exp_c[k-1])) begin
        errors++;
        $display("FAIL basic_count cyc %0d: got %0d expected %0d", k, count, exp_c[k-1]);
      end
      checks++;
      if (done !== (k == 17)) begin
        errors++;
        $display("FAIL basic_done cyc %0d: got %b expected %b", k, done, k == 17);
      end
      checks++;
      if (busy !== (k <= 16)) begin
        errors++;
        $display("FAIL basic_busy cyc %0d: got %b expected %b", k, busy, k <= 16);
      end
      if (k == 11) begin
        checks++;
        if (sweep_cnt !== 8'd1) begin
          errors++;
          $display("FAIL basic_sweep_mid: got %0d expected 1", sweep_cnt);
        end
      end
      if (k >= 17) begin
        checks++;
        if (sweep_cnt !== 8'd2) begin
          errors++;
          $display("FAIL basic_sweep_end cyc %0d: got %0d expected 2", k, sweep_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_reject;
    int rl[3] = '{5, 6, 2};
    int rh[3] = '{5, 3, 5};
    int rn[3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      start_run(rl[i], rh[i], rn[i]);
      checks++;
      if ({err, busy, cnt_en} !== 3'b100) begin
        errors++;
        $display("FAIL reject_%0d: err/busy/en got %b expected 100", i, {err, busy, cnt_en});
      end
      tick();
      checks++;
      if ({err, busy} !== 2'b00) begin
        errors++;
        $display("FAIL reject_pulse_%0d: err/busy got %b expected 00", i, {err, busy});
      end
    end
  endtask

  task automatic test_abort;
    int exp_c[6] = '{2,2,3,4,5,4};
    start_run(2, 5, 2);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (count !== 8'(exp_c[k-1])) begin
        errors++;
        $display("FAIL abort_count cyc %0d: got %0d expected %0d", k, count, exp_c[k-1]);
      end
      if (k < 6) tick();
    end
    abort = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_en: got %b expected 0", cnt_en);
    end
    tick();
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy, done, err} !== 3'b000 || count !== 8'd4 || sweep_cnt !== 8'd0) begin
        errors++;
        $display("FAIL abort_after %0d: busy/done/err %b count %0d sweep %0d expected 000 4 0",
                 k, {busy, done, err}, count, sweep_cnt);
      end
      tick();
    end
  endtask

  task automatic test_seek_down;
    int exp_t[7] = '{10,11,12,11,10,10,10};
    int e;
    load_val = 8'd200;
    load = 1'b1;
    tick();
    load = 1'b0;
    start_run(10, 12, 1);
    for (int k = 1; k <= 198; k++) begin
      e = (k <= 191) ? 201 - k : exp_t[k-192];
      checks++;
      if (count !== 8'(e)) begin
        errors++;
        $display("FAIL seek_count cyc %0d: got %0d expected %0d", k, count, e);
      end
      checks++;
      if (done !== (k == 197)) begin
        errors++;
        $display("FAIL seek_done cyc %0d: got %b expected %b", k, done, k == 197);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int exp_c[9] = '{10,10,11,12,13,12,11,10,10};
    start_run(10, 13, 1);
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin
        lo = 8'd0; hi = 8'd50; n_sweeps = 8'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      checks++;
      if (count !== 8'(exp_c[k-1]) || err !== 1'b0 || done !== (k == 9)) begin
        errors++;
        $display("FAIL busy_start cyc %0d: count %0d err %b done %b expected %0d 0 %b",
                 k, count, err, done, exp_c[k-1], k == 9);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (sweep_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_end: sweep %0d busy %b expected 1 0", sweep_cnt, busy);
    end
    lo = 8'd0; hi = 8'd9; n_sweeps = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({busy, err, cnt_en} !== 3'b000 || count !== 8'd10) begin
        errors++;
        $display("FAIL start_abort %0d: busy/err/en %b count %0d expected 000 10",
                 k, {busy, err, cnt_en}, count);
      end
      tick();
    end
  endtask

  task automatic test_async_reset;
    start_run(10, 20, 1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, cnt_en, done, err} !== 4'b0000 || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: busy/en/done/err %b sweep %0d expected 0000 0",
               {busy, cnt_en, done, err}, sweep_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_after: busy %b count %0d expected 0 0", busy, count);
    end
  endtask

`ifdef SWEEP_DWELL_EN
  task automatic test_dwell;
    int exp_c[21] = '{0,0,1,2,2,2,2,1,0,0,0,0,1,2,2,2,2,1,0,0,0};
    start_run(0, 2, 2);
    for (int k = 1; k <= 21; k++) begin
      checks++;
      if (count !== 8'(exp_c[k-1]) || done !== (k == 20) || busy !== (k <= 19)) begin
        errors++;
        $display("FAIL dwell cyc %0d: count %0d done %b busy %b expected %0d %b %b",
                 k, count, done, busy, exp_c[k-1], k == 20, k <= 19);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reject();
`ifdef SWEEP_DWELL_EN
    test_dwell();
`else
    test_basic();
    test_abort();
    test_seek_down();
    test_back_to_back();
    test_async_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
